// File: rtl/ncc_pkg.sv
// rtl/ncc_pkg.sv - shared constants and FSM state type for the NCC window controller
package ncc_pkg;

  localparam int ROW_PIXELS_DEF = 80;
  localparam int NUM_ROWS_DEF   = 16;
  localparam int DESC_W_DEF     = 16;
  localparam int ADDR_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-N up-counter with enable, synchronous clear and wrap pulse
module wrap_counter #(
  parameter int N = 16,
  parameter int W = $clog2(N - 1) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // wrap_o marks the enabled step that returns the count to zero
  assign wrap_o = en_i && (cnt_q == W'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ncc_window_ctrl.sv
// rtl/ncc_window_ctrl.sv - fills the row BRAM window, then scans descriptor-wide columns per offset
module ncc_window_ctrl
  import ncc_pkg::*;
#(
  parameter int ROW_PIXELS = ROW_PIXELS_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int DESC_W     = DESC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [NUM_ROWS-1:0] wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [7:0]          wr_data,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                corr_ready,
  output logic                rd_valid,
  output logic                rd_first,
  output logic                rd_last,
  output logic [ADDR_W-1:0]   offset,
  output logic                busy,
  output logic                done
);

  localparam int NOFF  = ROW_PIXELS - DESC_W + 1;
  localparam int COL_W = $clog2(ROW_PIXELS - 1) + 1;
  localparam int ROW_W = $clog2(NUM_ROWS - 1) + 1;
  localparam int K_W   = $clog2(DESC_W - 1) + 1;
  localparam int OFF_W = $clog2(NOFF - 1) + 1;

  state_e state_q, state_d;

  logic             start_act, abort_act, accept, issue, cnt_clr;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [K_W-1:0]   k_cnt;
  logic [OFF_W-1:0] off_cnt;
  logic             col_wrap, row_wrap, k_wrap, off_wrap;

  logic              rd_valid_q, rd_valid_d;
  logic              rd_first_q, rd_first_d;
  logic              rd_last_q, rd_last_d;
  logic [ADDR_W-1:0] offset_q, offset_d;

  assign start_act = (state_q == ST_IDLE) && start;
  assign abort_act = abort && ((state_q == ST_FILL) || (state_q == ST_SCAN));
  // abort outranks both the pixel handshake and the column issue
  assign accept    = (state_q == ST_FILL) && pix_valid && !abort;
  assign issue     = (state_q == ST_SCAN) && corr_ready && !abort;
  assign cnt_clr   = start_act || abort_act;

  wrap_counter #(.N(ROW_PIXELS), .W(COL_W)) u_col (
    .clk(clk), .rst(rst), .en_i(accept), .clr_i(cnt_clr), .cnt_o(col_cnt), .wrap_o(col_wrap)
  );

  wrap_counter #(.N(NUM_ROWS), .W(ROW_W)) u_row (
    .clk(clk), .rst(rst), .en_i(col_wrap), .clr_i(cnt_clr), .cnt_o(row_cnt), .wrap_o(row_wrap)
  );

  wrap_counter #(.N(DESC_W), .W(K_W)) u_k (
    .clk(clk), .rst(rst), .en_i(issue), .clr_i(cnt_clr), .cnt_o(k_cnt), .wrap_o(k_wrap)
  );

  wrap_counter #(.N(NOFF), .W(OFF_W)) u_off (
    .clk(clk), .rst(rst), .en_i(k_wrap), .clr_i(cnt_clr), .cnt_o(off_cnt), .wrap_o(off_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FILL;
      ST_FILL: begin
        if (abort)         state_d = ST_IDLE;
        else if (row_wrap) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort)         state_d = ST_IDLE;
        else if (off_wrap) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d = issue;
    rd_first_d = issue && (k_cnt == '0);
    rd_last_d  = issue && (k_cnt == K_W'(DESC_W - 1));
    offset_d   = issue ? ADDR_W'(off_cnt) : offset_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      offset_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      offset_q   <= offset_d;
    end
  end

  assign pix_ready = (state_q == ST_FILL) && !abort;
  assign wr_en     = accept ? (NUM_ROWS'(1) << row_cnt) : '0;
  assign wr_addr   = ADDR_W'(col_cnt);
  assign wr_data   = pix_data;
  // counters idle at zero outside SCAN, so the read address rests at 0
  assign rd_addr   = ADDR_W'(off_cnt) + ADDR_W'(k_cnt);
  assign rd_valid  = rd_valid_q;
  assign rd_first  = rd_first_q;
  assign rd_last   = rd_last_q;
  assign offset    = offset_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ncc_window_ctrl.sv
// tb/tb_ncc_window_ctrl.sv - randomized self-checking bench with a behavioural window/scan model
module tb_ncc_window_ctrl;

  localparam int RP     = 80;
  localparam int NR     = 16;
  localparam int DW     = 16;
  localparam int NPIX   = RP * NR;
  localparam int NOFF   = RP - DW + 1;
  localparam int NCOL   = NOFF * DW;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, pix_valid, corr_ready;
  logic [7:0]  pix_data;
  logic        pix_ready, rd_valid, rd_first, rd_last, busy, done;
  logic [15:0] wr_en;
  logic [9:0]  wr_addr, rd_addr, offset;
  logic [7:0]  wr_data;

  ncc_window_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .corr_ready(corr_ready),
    .rd_valid(rd_valid), .rd_first(rd_first), .rd_last(rd_last),
    .offset(offset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  // model: phase 0 idle, 1 fill, 2 scan, 3 done; m_n pixels taken, m_i columns issued
  int m_ph, m_n, m_i, m_off;
  bit m_rv, m_first, m_last;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_n <= 0; m_i <= 0; m_off <= 0;
      m_rv <= 0; m_first <= 0; m_last <= 0;
    end else begin
      bit iss;
      iss = (m_ph == 2) && corr_ready && !abort;
      m_rv    <= iss;
      m_first <= iss && (m_i % DW == 0);
      m_last  <= iss && (m_i % DW == DW - 1);
      if (iss) m_off <= m_i / DW;
      case (m_ph)
        0: if (start) begin m_ph <= 1; m_n <= 0; m_i <= 0; end
        1: if (abort) m_ph <= 0;
           else if (pix_valid) begin
             m_n <= m_n + 1;
             if (m_n == NPIX - 1) m_ph <= 2;
           end
        2: if (abort) m_ph <= 0;
           else if (corr_ready) begin
             m_i <= m_i + 1;
             if (m_i == NCOL - 1) m_ph <= 3;
           end
        default: m_ph <= 0;
      endcase
    end
  end

  int cyc = 0;
  int st_rv = 0, st_first = 0, st_last = 0, st_done = 0, st_done_rv = 0;
  int st_last_off = 0, st_last_addr = 0, st_start_cyc = 0, st_rv0_cyc = 0;
  int st_row_wr[NR];

  initial for (int r = 0; r < NR; r++) st_row_wr[r] = 0;

  always @(negedge clk) begin
    bit acc, iss;
    logic [15:0] e_wr_en;
    logic [9:0]  e_rd_addr;
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_valid", {rd_valid, rd_first, rd_last}, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_offset", offset, 0);
    end else begin
      acc = (m_ph == 1) && pix_valid && !abort;
      iss = (m_ph == 2) && corr_ready && !abort;
      e_wr_en   = acc ? 16'(1 << (m_n / RP)) : 16'h0;
      e_rd_addr = (m_ph == 2) ? 10'(m_i / DW + m_i % DW) : 10'd0;
      chk("busy", busy, m_ph != 0);
      chk("done", done, m_ph == 3);
      chk("pix_ready", pix_ready, (m_ph == 1) && !abort);
      chk("wr_en", wr_en, e_wr_en);
      if (acc) begin
        chk("wr_addr", wr_addr, m_n % RP);
        chk("wr_data", wr_data, pix_data);
      end
      chk("rd_addr", rd_addr, e_rd_addr);
      chk("rd_valid", rd_valid, m_rv);
      chk("rd_first", rd_first, m_first);
      chk("rd_last", rd_last, m_last);
      if (m_rv) chk("offset", offset, m_off);
      if (acc && m_n == 0)        chk("pin_px0", {wr_en, wr_addr}, {16'h0001, 10'd0});
      if (acc && m_n == 81)       chk("pin_px81", {wr_en, wr_addr}, {16'h0002, 10'd1});
      if (acc && m_n == NPIX - 1) chk("pin_px_last", {wr_en, wr_addr}, {16'h8000, 10'd79});
      if (iss && m_i == 17)       chk("pin_col17", rd_addr, 10'd2);
      if (iss && m_i == NCOL - 1) chk("pin_col_last", rd_addr, 10'd79);
      if (m_rv && m_last && m_off == NOFF - 1) chk("pin_done_with_last", done, 1);

      if (m_ph == 0 && start) st_start_cyc = cyc;
      if (iss) st_last_addr = rd_addr;
      if (rd_valid) begin
        st_rv++;
        st_last_off = offset;
        if (rd_first && offset == 0) st_rv0_cyc = cyc;
      end
      if (rd_first) st_first++;
      if (rd_last) st_last++;
      if (done) st_done++;
      if (done && rd_valid) st_done_rv++;
      for (int r = 0; r < NR; r++) if (wr_en[r]) st_row_wr[r]++;
    end
  end

  function automatic bit pick(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic drive_pix();
    pix_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      start = 0; pix_valid = 1; corr_ready = 1; abort = $urandom_range(0, 1); drive_pix();
    end
    @(posedge clk); #1;
    abort = 0;
  endtask

  task automatic run_job(input int vm, input int rm, input int abort_at, input int rst_off,
                         input bit start_scan);
    int  c;
    bit  fin;
    c = 0; fin = 0;
    @(posedge clk); #1;
    start = 1; abort = 0; pix_valid = pick(vm, 0); corr_ready = pick(rm, 0); drive_pix();
    while (!fin && c < 8000) begin
      @(posedge clk); #1;
      c++;
      start = 0; abort = 0;
      if (m_ph == 0) begin
        fin = 1;
      end else begin
        pix_valid  = pick(vm, c);
        corr_ready = pick(rm, c);
        drive_pix();
        if (start_scan && m_ph == 2 && $urandom_range(0, 7) == 0) start = 1;
        if (abort_at >= 0 && m_ph == 1 && m_n == abort_at) begin
          pix_valid = 1; abort = 1;
          #1;
          chk("abort_wr_en", wr_en, 0);
          @(posedge clk); #1;
          abort = 0;
          chk("abort_busy", busy, 0);
          fin = 1;
        end else if (rst_off >= 0 && m_ph == 2 && m_i / DW == rst_off && m_i % DW == 5) begin
          rst = 1;
          #1;
          chk("midrst_busy", busy, 0);
          chk("midrst_rd_valid", rd_valid, 0);
          chk("midrst_rd_addr", rd_addr, 0);
          chk("midrst_offset", offset, 0);
          @(posedge clk); #1;
          rst = 0;
          fin = 1;
        end
      end
    end
    if (!fin) chk("job_timeout", 1, 0);
    start = 0; abort = 0;
  endtask

  int b_rv, b_first, b_last, b_done, b_done_rv, b_row[NR];

  task automatic snap();
    b_rv = st_rv; b_first = st_first; b_last = st_last; b_done = st_done; b_done_rv = st_done_rv;
    for (int r = 0; r < NR; r++) b_row[r] = st_row_wr[r];
  endtask

  task automatic check_full_scan(input string tag);
    chk({tag, "_rv_count"}, st_rv - b_rv, NCOL);
    chk({tag, "_first_count"}, st_first - b_first, NOFF);
    chk({tag, "_last_count"}, st_last - b_last, NOFF);
    chk({tag, "_done_count"}, st_done - b_done, 1);
    chk({tag, "_done_with_rv"}, st_done_rv - b_done_rv, 1);
    chk({tag, "_final_offset"}, st_last_off, NOFF - 1);
    chk({tag, "_final_rd_addr"}, st_last_addr, RP - 1);
  endtask

  initial begin
    int rows_ok;
    rst = 1; start = 0; abort = 0; pix_valid = 0; corr_ready = 0; pix_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(3);

    snap();
    run_job(0, 0, -1, -1, 0);
    check_full_scan("cont");
    chk("scan_entry_cycle", st_rv0_cyc - 1 - st_start_cyc + 1, 1282);
    rows_ok = 0;
    for (int r = 0; r < NR; r++) if (st_row_wr[r] - b_row[r] == RP) rows_ok++;
    chk("rows_with_80_writes", rows_ok, NR);

    snap();
    run_job(1, 1, -1, -1, 0);
    check_full_scan("toggle");

    snap();
    run_job(2, 2, 500, -1, 0);
    chk("abort_no_done", st_done - b_done, 0);
    idle(2);
    snap();
    run_job(2, 2, -1, -1, 1);
    check_full_scan("restart");

    snap();
    run_job(0, 1, -1, 30, 1);
    chk("midrst_no_done", st_done - b_done, 0);
    idle(5);

    snap();
    run_job(2, 2, -1, -1, 1);
    check_full_scan("random");
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
